rx_iq_serializer: RTL

Downstream of the receive decimation chain: buffers each 24-bit I/Q output pair in a small FIFO. Emits the pairs to the host MCU over a free-running left-justified I2S-style serial link (bit clock, word select, data), one 64-bit frame per sample pair. The link is clocked entirely from the receiver master clock. FIFO depth decouples decimator strobe jitter from the fixed frame rate.

---
 rtl/rx_iq_serializer_if.sv | 26 ++
 rtl/rx_iq_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rx_iq_serializer_if.sv
// rx_iq_serializer_if
//   Sample input bus and serial link of rx_iq_serializer.
//   in_strobe          one-cycle pulse, in_real/in_imag valid that cycle
//   in_real, in_imag   signed I and Q samples (DATA_W bits)
//   sclk, lrclk, sdata I2S-style bit clock, word select, serial data
//   master: the sample source / link observer; slave: the serializer.
interface rx_iq_serializer_if #(
    parameter int DATA_W = 24
);
    logic                     in_strobe;
    logic signed [DATA_W-1:0] in_real;
    logic signed [DATA_W-1:0] in_imag;
    logic                     sclk;
    logic                     lrclk;
    logic                     sdata;

    modport master (
        output in_strobe, in_real, in_imag,
        input  sclk, lrclk, sdata
    );

    modport slave (
        input  in_strobe, in_real, in_imag,
        output sclk, lrclk, sdata
    );
endinterface

// File: rtl/rx_iq_serializer.sv
// rx_iq_serializer
//   Buffers 24-bit I/Q pairs from the decimation chain in a FIFO and sends
//   one pair per 64-bit left-justified I2S-style frame, clocked from the
//   master clock. Frame: I[23:0], 8 zeros, Q[23:0], 8 zeros, MSB first;
//   lrclk low for the I half, high for the Q half.
// Ports
//   clock, reset   master clock, synchronous active-high reset
//   bus (slave)    in_strobe/in_real/in_imag in, sclk/lrclk/sdata out
//   clear_flags    clears the sticky overflow/underflow flags
//   fifo_level     FIFO occupancy (0..2^FIFO_AW)
//   overflow       sticky: a write was dropped on a full FIFO
//   underflow      sticky: an empty frame was sent after the first pop
//   ovf_count      saturating dropped-write count
// Build option
//   RXSER_OVF_COUNT_EN  defined: ovf_count is a live counter;
//                       undefined: ovf_count is tied to zero.
module rx_iq_serializer #(
    parameter int SCLK_DIV = 50,
    parameter int FIFO_AW  = 4
) (
    input  logic               clock,
    input  logic               reset,
    rx_iq_serializer_if.slave  bus,
    input  logic               clear_flags,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               underflow,
    output logic [15:0]        ovf_count
);
    localparam int DATA_W  = 24;
    localparam int PAIR_W  = 2 * DATA_W;
    localparam int FRAME_W = 64;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int PH_W    = $clog2(SCLK_DIV);
    localparam logic [PH_W-1:0]    PH_LAST = PH_W'(SCLK_DIV - 1);
    localparam logic [PH_W-1:0]    PH_HALF = PH_W'(SCLK_DIV / 2);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic {PRIME, RUN} state_t;

    state_t               state, state_nxt;
    logic [PH_W-1:0]      phase, phase_nxt;
    logic [5:0]           bit_cnt;
    logic                 first_p0;
    logic                 frame_load;
    logic                 uf_set;

    logic [PAIR_W-1:0]    mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [PAIR_W-1:0]    head;
    logic                 full, empty, push, pop, drop;

    logic [FRAME_W-1:0]   shift_p0;
    logic [FRAME_W-1:0]   new_frame;
    logic [FRAME_W-1:0]   frame_src;

    assign phase_nxt  = (phase == PH_LAST) ? '0 : phase + 1'b1;
    // first_p0 forces a load in the cycle right after reset so the link
    // restarts on a clean (zero) frame.
    assign frame_load = ((phase == PH_LAST) && (bit_cnt == 6'd63)) || first_p0;

    assign full  = (fifo_level == LVL_FULL);
    assign empty = (fifo_level == '0);
    assign pop   = frame_load && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push  = bus.in_strobe && (!full || pop);
    assign drop  = bus.in_strobe && full && !pop;

    assign head      = mem[rd_ptr];
    assign new_frame = pop ? {head[PAIR_W-1:DATA_W], 8'h00, head[DATA_W-1:0], 8'h00}
                           : '0;
    // In the post-reset load cycle the frame being loaded is also the one
    // whose first bit goes out, so bypass the shift register.
    assign frame_src = first_p0 ? new_frame : shift_p0;

    // Control: bit timing, FIFO pointers, flags
    always_ff @(posedge clock) begin
        if (reset) begin
            phase      <= '0;
            bit_cnt    <= '0;
            first_p0   <= 1'b1;
            bus.sclk   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            first_p0 <= 1'b0;
            bus.sclk <= (phase_nxt >= PH_HALF);
            if (phase == PH_LAST)
                bit_cnt <= bit_cnt + 6'd1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clear_flags)
                overflow <= 1'b0;
            if (uf_set)
                underflow <= 1'b1;
            else if (clear_flags)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= PRIME;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        uf_set    = 1'b0;
        case (state)
            PRIME: if (pop) state_nxt = RUN;
            RUN:   if (frame_load && empty) uf_set = 1'b1;
            default: state_nxt = PRIME;
        endcase
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (push && !reset)
            mem[wr_ptr] <= {bus.in_real, bus.in_imag};
    end

    // Stage p0: frame shift register
    always_ff @(posedge clock) begin
        if (frame_load && !first_p0)
            shift_p0 <= new_frame;
        else if (phase == '0)
            shift_p0 <= {frame_src[FRAME_W-2:0], 1'b0};
    end

    // Stage p1: serial output registers, updated once per bit at phase 0
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.sdata <= 1'b0;
            bus.lrclk <= 1'b0;
        end else if (phase == '0) begin
            bus.sdata <= frame_src[FRAME_W-1];
            bus.lrclk <= bit_cnt[5];
        end
    end

`ifdef RXSER_OVF_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset)
            ovf_count <= '0;
        else if (drop)
            ovf_count <= sat_inc16(ovf_count);
        else if (clear_flags)
            ovf_count <= '0;
    end
`else
    assign ovf_count = '0;
`endif

endmodule
